dcache_port_arbiter: RTL and testbench

Sequencer and arbiter for the single data-cache port shared by backend loads and retire-stage stores. Grants one requester at a time, drives the cache request/response handshake, returns load data tagged with the ROB index, and discards load responses killed by a pipeline flush. Emits busy indications consumed by hazard detection to form backend and retire stalls.

---
 rtl/dcache_port_arbiter_if.sv | 47 ++++
 rtl/dcache_port_arbiter.sv | 135 +++++++++++++
 tb/tb_dcache_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Handshake bundle between load/store requesters, the data cache and the port arbiter.
// Latency: none (wires only).
// Backpressure: the arbiter side drives grants and busy; the environment side drives c_ready/c_valid.
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6
);
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_gnt;
    logic              ld_done;
    logic [TAG_W-1:0]  ld_done_tag;
    logic [DATA_W-1:0] ld_data;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_size;
    logic              st_gnt;
    logic              st_done;
    logic              flush;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [1:0]        c_size;
    logic              c_ready;
    logic              c_valid;
    logic [DATA_W-1:0] c_rdata;
    logic              backend_busy;
    logic              retire_busy;

    modport slave (
        input  ld_req, ld_addr, ld_tag, st_req, st_addr, st_data, st_size, flush,
               c_ready, c_valid, c_rdata,
        output ld_gnt, ld_done, ld_done_tag, ld_data, st_gnt, st_done,
               c_req, c_we, c_addr, c_wdata, c_size, backend_busy, retire_busy
    );

    modport master (
        output ld_req, ld_addr, ld_tag, st_req, st_addr, st_data, st_size, flush,
               c_ready, c_valid, c_rdata,
        input  ld_gnt, ld_done, ld_done_tag, ld_data, st_gnt, st_done,
               c_req, c_we, c_addr, c_wdata, c_size, backend_busy, retire_busy
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Arbitrates backend loads and retire stores onto the single data-cache port; one request in flight.
// Latency: grant at T, c_req at T+1, done pulse at T+2 at the earliest.
// Backpressure: requests hold until their combinational grant; c_req holds its fields until c_ready.
module dcache_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int TAG_W        = 6,
    parameter int STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  reset,
    dcache_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_REQ, STORE_REQ, WAIT, DROP} state_t;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic [TAG_W-1:0]  req_tag;
    logic              req_is_st;
    logic              killed;
    logic              idle, starved, ld_win, st_win, complete;
    logic              ld_done_nxt, st_done_nxt;
    logic              ld_done_q, st_done_q;
    logic [DATA_W-1:0] ld_data_q;
    logic [TAG_W-1:0]  ld_done_tag_q;

    // Grants and busy are gated by reset so every output is low while it is asserted.
    assign idle    = (state == IDLE);
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign ld_win  = reset & idle & bus.ld_req & ~bus.flush & (~bus.st_req | starved);
    assign st_win  = reset & idle & bus.st_req & ~ld_win;

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_win)      state_nxt = LOAD_REQ;
                else if (st_win) state_nxt = STORE_REQ;
            end
            LOAD_REQ, STORE_REQ: begin
                if (bus.c_ready) begin
                    if (bus.c_valid) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else if (state == LOAD_REQ && (killed || bus.flush)) begin
                        state_nxt = DROP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.c_valid) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.flush && !req_is_st) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (bus.c_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A flush in the completion cycle still suppresses the load's done pulse.
    assign ld_done_nxt = complete & ~req_is_st & ~killed & ~bus.flush;
    assign st_done_nxt = complete & req_is_st;

    always_comb begin
        starve_nxt = starve_cnt;
        if (ld_win || !bus.ld_req)   starve_nxt = '0;
        else if (st_win && !starved) starve_nxt = starve_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_size      <= '0;
            req_tag       <= '0;
            req_is_st     <= 1'b0;
            killed        <= 1'b0;
            ld_done_q     <= 1'b0;
            st_done_q     <= 1'b0;
            ld_data_q     <= '0;
            ld_done_tag_q <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            ld_done_q  <= ld_done_nxt;
            st_done_q  <= st_done_nxt;
            if (ld_win) begin
                req_addr  <= bus.ld_addr;
                req_wdata <= '0;
                req_size  <= 2'd3;
                req_tag   <= bus.ld_tag;
                req_is_st <= 1'b0;
            end else if (st_win) begin
                req_addr  <= bus.st_addr;
                req_wdata <= bus.st_data;
                req_size  <= bus.st_size;
                req_is_st <= 1'b1;
            end
            if (ld_win || st_win)                      killed <= 1'b0;
            else if (state == LOAD_REQ && bus.flush)   killed <= 1'b1;
            if (ld_done_nxt) begin
                ld_data_q     <= bus.c_rdata;
                ld_done_tag_q <= req_tag;
            end
        end
    end

    assign bus.ld_gnt       = ld_win;
    assign bus.st_gnt       = st_win;
    assign bus.ld_done      = ld_done_q;
    assign bus.st_done      = st_done_q;
    assign bus.ld_data      = ld_data_q;
    assign bus.ld_done_tag  = ld_done_tag_q;
    assign bus.c_req        = (state == LOAD_REQ) || (state == STORE_REQ);
    assign bus.c_we         = (state == STORE_REQ);
    assign bus.c_addr       = req_addr;
    assign bus.c_wdata      = req_wdata;
    assign bus.c_size       = req_size;
    assign bus.backend_busy = reset & (~idle | (bus.ld_req & ~ld_win));
    assign bus.retire_busy  = reset & (~idle | (bus.st_req & ~st_win));
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized bench for dcache_port_arbiter: a transaction-level model predicts grants, cache
// request fields and done pulses; a separate monitor checks load data/tags against a queue.
module tb_dcache_port_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 6;
    localparam int LIMIT  = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ld_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dcache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    dcache_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    // Transaction-level model state, owned by the checker process.
    bit                active, accepted, cur_st, cur_killed;
    bit                due_ld, due_st, ld_taken, st_taken;
    bit                chk_en, rec;
    int                starve;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [1:0]        cur_size;
    ld_exp_t           ld_q[$];
    int                st_q[$];
    bit                gseq[$];
    int                p_ld, p_st, p_rdy, p_vld, p_flush;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_of(input logic [ADDR_W-1:0] a);
        return {a[31:0], ~a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Requesters hold until granted; the cache answers with data derived from the address.
    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (!bus.ld_req || ld_taken) begin
            bus.ld_req  = roll(p_ld);
            bus.ld_addr = {$urandom, $urandom};
            bus.ld_tag  = TAG_W'($urandom);
        end
        if (!bus.st_req || st_taken) begin
            bus.st_req  = roll(p_st);
            bus.st_addr = {$urandom, $urandom};
            bus.st_data = {$urandom, $urandom};
            bus.st_size = 2'($urandom_range(3));
        end
        ld_taken  = 1'b0;
        st_taken  = 1'b0;
        bus.flush = roll(p_flush);
        if (bus.c_req) begin
            bus.c_ready = roll(p_rdy);
            bus.c_valid = bus.c_ready && roll(p_vld);
        end else if (active && accepted) begin
            bus.c_ready = 1'($urandom_range(1));
            bus.c_valid = roll(p_vld);
        end else begin
            bus.c_ready = 1'($urandom_range(1));
            bus.c_valid = roll(10);
        end
        bus.c_rdata = active ? rd_of(cur_addr) : {$urandom, $urandom};
    endtask

    always @(negedge clk) begin
        bit      exp_l, exp_s, fin;
        ld_exp_t e;
        if (reset && chk_en) begin
            check("ld_done_pulse", bus.ld_done, due_ld);
            check("st_done_pulse", bus.st_done, due_st);
            due_ld = 1'b0;
            due_st = 1'b0;
            exp_l = !active && bus.ld_req && !bus.flush && (!bus.st_req || starve == LIMIT);
            exp_s = !active && bus.st_req && !exp_l;
            check("ld_gnt", bus.ld_gnt, exp_l);
            check("st_gnt", bus.st_gnt, exp_s);
            check("backend_busy", bus.backend_busy, active || (bus.ld_req && !exp_l));
            check("retire_busy", bus.retire_busy, active || (bus.st_req && !exp_s));
            if (rec && (bus.ld_gnt || bus.st_gnt)) gseq.push_back(bus.ld_gnt);
            if (exp_l || !bus.ld_req)      starve = 0;
            else if (exp_s && starve < LIMIT) starve++;
            if (active) begin
                if (!accepted) begin
                    check("c_req", bus.c_req, 1'b1);
                    check("c_we", bus.c_we, cur_st);
                    check("c_addr", bus.c_addr, cur_addr);
                    check("c_size", bus.c_size, cur_size);
                    if (cur_st) check("c_wdata", bus.c_wdata, cur_wdata);
                end else begin
                    check("c_req_wait", bus.c_req, 1'b0);
                end
                if (!cur_st && bus.flush && !cur_killed) begin
                    cur_killed = 1'b1;
                    e = ld_q.pop_back();
                end
                fin = (accepted || bus.c_ready) && bus.c_valid;
                if (bus.c_ready) accepted = 1'b1;
                if (fin) begin
                    active = 1'b0;
                    due_ld = !cur_st && !cur_killed;
                    due_st = cur_st;
                end
            end else begin
                check("c_req_idle", bus.c_req, 1'b0);
            end
            ld_taken = exp_l;
            st_taken = exp_s;
            if (exp_l || exp_s) begin
                active     = 1'b1;
                accepted   = 1'b0;
                cur_killed = 1'b0;
                cur_st     = exp_s;
                cur_addr   = exp_s ? bus.st_addr : bus.ld_addr;
                cur_size   = exp_s ? bus.st_size : 2'd3;
                cur_wdata  = bus.st_data;
                if (exp_l) begin
                    e.tag  = bus.ld_tag;
                    e.data = rd_of(bus.ld_addr);
                    ld_q.push_back(e);
                end else begin
                    st_q.push_back(1);
                end
            end
        end
    end

    // Monitor: consumes expected responses whenever the DUT reports a completion.
    always @(negedge clk) begin
        ld_exp_t e;
        int      s;
        if (reset) begin
            if (bus.ld_done) begin
                check("ld_q_nonempty", ld_q.size() != 0, 1'b1);
                if (ld_q.size() != 0) begin
                    e = ld_q.pop_front();
                    check("ld_done_tag", bus.ld_done_tag, e.tag);
                    check("ld_data", bus.ld_data, e.data);
                end
            end
            if (bus.st_done) begin
                check("st_q_nonempty", st_q.size() != 0, 1'b1);
                if (st_q.size() != 0) s = st_q.pop_front();
            end
        end
    end

    task automatic set_knobs(input int l, input int s, input int r, input int v, input int f);
        p_ld = l; p_st = s; p_rdy = r; p_vld = v; p_flush = f;
    endtask

    task automatic clear_model();
        active = 0; accepted = 0; due_ld = 0; due_st = 0;
        ld_taken = 0; st_taken = 0; starve = 0;
        ld_q.delete();
        st_q.delete();
    endtask

    initial begin
        int n;
        {bus.ld_req, bus.st_req, bus.flush, bus.c_ready, bus.c_valid} = '0;
        bus.ld_addr = '0; bus.ld_tag = '0; bus.st_addr = '0; bus.st_data = '0;
        bus.st_size = '0; bus.c_rdata = '0;
        chk_en = 1'b0;
        rec = 1'b0;
        clear_model();
        set_knobs(0, 0, 100, 100, 0);
        repeat (3) @(negedge clk);
        check("rst_ld_done", bus.ld_done, 1'b0);
        check("rst_ld_data", bus.ld_data, 64'd0);
        check("rst_ld_done_tag", bus.ld_done_tag, 64'd0);
        check("rst_st_done", bus.st_done, 1'b0);
        check("rst_c_req", bus.c_req, 1'b0);
        check("rst_c_addr", bus.c_addr, 64'd0);
        check("rst_busy", {bus.backend_busy, bus.retire_busy}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        set_knobs(60, 50, 60, 50, 8);
        repeat (3000) drive_cycle();
        set_knobs(0, 0, 100, 100, 0);
        repeat (20) drive_cycle();
        check("drain_ld_q", ld_q.size(), 64'd0);
        check("drain_st_q", st_q.size(), 64'd0);

        // Both requesters saturated: four stores then a forced load, repeating.
        gseq.delete();
        rec = 1'b1;
        set_knobs(100, 100, 100, 100, 0);
        repeat (60) drive_cycle();
        rec = 1'b0;
        check("starve_seq_len", gseq.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < gseq.size(); i++)
            check("starve_seq", gseq[i], (i % 5) == 4);
        set_knobs(0, 0, 100, 100, 0);
        repeat (20) drive_cycle();

        // Reset while a store waits on c_ready; its done pulse must never appear.
        set_knobs(0, 100, 0, 0, 0);
        n = 0;
        while (!(bus.c_req && bus.c_we) && n < 200) begin
            drive_cycle();
            n++;
        end
        check("store_req_reached", bus.c_req && bus.c_we, 1'b1);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("mid_rst_c_req", bus.c_req, 1'b0);
        check("mid_rst_c_we", bus.c_we, 1'b0);
        check("mid_rst_c_addr", bus.c_addr, 64'd0);
        check("mid_rst_st_gnt", bus.st_gnt, 1'b0);
        check("mid_rst_retire_busy", bus.retire_busy, 1'b0);
        check("mid_rst_ld_data", bus.ld_data, 64'd0);
        {bus.ld_req, bus.st_req, bus.flush, bus.c_ready, bus.c_valid} = '0;
        clear_model();
        set_knobs(0, 0, 100, 100, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (10) drive_cycle();
        check("post_rst_st_q", st_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
